// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller.
//   fwd_sel_e  : EX-stage operand source select encoding
//   slot_t     : one shadow-pipeline slot (destination and source register info)
//   REG_ZERO   : architectural x0, which never produces or consumes a hazard
//   slot_writes: true when a slot will architecturally write a non-x0 register
//   fwd_src    : picks the youngest in-flight producer for one EX operand
package hazard_pkg;

    localparam int unsigned SLOT_AW = 5;

    localparam logic [SLOT_AW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic               valid;
        logic [SLOT_AW-1:0] rd;
        logic               reg_write;
        logic               mem_read;
        logic [SLOT_AW-1:0] rs1;
        logic [SLOT_AW-1:0] rs2;
        logic               use_rs1;
        logic               use_rs2;
    } slot_t;

    function automatic logic slot_writes(input slot_t s);
        return s.valid & s.reg_write & (s.rd != REG_ZERO);
    endfunction

    // MEM wins over WB because it holds the younger producer. A load in MEM
    // has no data yet, so it never forwards from there.
    function automatic fwd_sel_e fwd_src(input slot_t mem_s, input slot_t wb_s,
                                         input logic [SLOT_AW-1:0] rs);
        if (slot_writes(mem_s) && !mem_s.mem_read && (mem_s.rd == rs))
            return FWD_MEM;
        else if (slot_writes(wb_s) && (wb_s.rd == rs))
            return FWD_WB;
        else
            return FWD_NONE;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
//   i_clk   : clock
//   i_rst   : asynchronous reset, clears the count
//   i_inc   : increment enable for this cycle
//   o_count : current count, holds at all-ones instead of wrapping
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_count <= '0;
        else if (i_inc && (r_count != '1))
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline.
// Keeps a shadow EX/MEM/WB pipeline of register-usage info that advances in
// lockstep with the datapath pipeline registers.
//   clk, rst                 : clock, asynchronous active-high reset
//   id_*                     : decoded fields of the instruction currently in ID
//   ex_mispredict            : branch/jump mispredict resolved in EX
//   mux_Sel_RAW_ID_rs1/rs2   : ID operand takes WB write data
//   ex_fwd_sel_rs1/rs2       : EX operand source (00 ID/EX, 01 MEM, 10 WB)
//   stall_if, stall_id       : load-use stall (hold PC, IF/ID, ID; bubble ID/EX)
//   flush_if_id, flush_id_ex : mispredict squash
//   stall_count, flush_count : saturating event counters
// REG_AW must equal hazard_pkg::SLOT_AW, which sizes the slot fields.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_mispredict,
    output logic              mux_Sel_RAW_ID_rs1,
    output logic              mux_Sel_RAW_ID_rs2,
    output logic [1:0]        ex_fwd_sel_rs1,
    output logic [1:0]        ex_fwd_sel_rs2,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    slot_t    r_ex, r_mem, r_wb;
    slot_t    w_id_slot;
    logic     w_load_use;
    logic     w_stall;
    fwd_sel_e w_fwd_rs1, w_fwd_rs2;

    always_comb begin
        w_id_slot = '{valid:     id_valid,
                      rd:        id_rd,
                      reg_write: id_reg_write,
                      mem_read:  id_mem_read,
                      rs1:       id_rs1,
                      rs2:       id_rs2,
                      use_rs1:   id_use_rs1,
                      use_rs2:   id_use_rs2};
    end

    assign w_load_use = id_valid & r_ex.mem_read & slot_writes(r_ex) &
                        ((id_use_rs1 & (r_ex.rd == id_rs1)) |
                         (id_use_rs2 & (r_ex.rd == id_rs2)));

    // A mispredict squashes the dependent instruction anyway, so it overrides
    // the stall rather than letting both fire.
    assign w_stall     = w_load_use & ~ex_mispredict;
    assign stall_if    = w_stall;
    assign stall_id    = w_stall;
    assign flush_if_id = ex_mispredict;
    assign flush_id_ex = ex_mispredict;

    assign mux_Sel_RAW_ID_rs1 = slot_writes(r_wb) & (r_wb.rd == id_rs1) & id_use_rs1;
    assign mux_Sel_RAW_ID_rs2 = slot_writes(r_wb) & (r_wb.rd == id_rs2) & id_use_rs2;

    always_comb begin
        w_fwd_rs1 = FWD_NONE;
        w_fwd_rs2 = FWD_NONE;
        if (r_ex.valid && r_ex.use_rs1)
            w_fwd_rs1 = fwd_src(r_mem, r_wb, r_ex.rs1);
        if (r_ex.valid && r_ex.use_rs2)
            w_fwd_rs2 = fwd_src(r_mem, r_wb, r_ex.rs2);
    end

    assign ex_fwd_sel_rs1 = w_fwd_rs1;
    assign ex_fwd_sel_rs2 = w_fwd_rs2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= (w_load_use || ex_mispredict) ? '0 : w_id_slot;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_inc   (w_stall),
        .o_count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_inc   (ex_mispredict),
        .o_count (flush_count)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, ex_mispredict;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic        b1, b2, st_if, st_id, fl_ifid, fl_idex;
    logic [1:0]  f1, f2;
    logic [31:0] sc, fc;

    logic        s_b1, s_b2, s_st_if, s_st_id, s_fl_ifid, s_fl_idex;
    logic [1:0]  s_f1, s_f2;
    logic [2:0]  s_sc, s_fc;

    always #5 clk = ~clk;

    hazard_ctrl_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_mispredict(ex_mispredict),
        .mux_Sel_RAW_ID_rs1(b1), .mux_Sel_RAW_ID_rs2(b2),
        .ex_fwd_sel_rs1(f1), .ex_fwd_sel_rs2(f2),
        .stall_if(st_if), .stall_id(st_id), .flush_if_id(fl_ifid), .flush_id_ex(fl_idex),
        .stall_count(sc), .flush_count(fc)
    );

    hazard_ctrl_unit #(.REG_AW(5), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_mispredict(ex_mispredict),
        .mux_Sel_RAW_ID_rs1(s_b1), .mux_Sel_RAW_ID_rs2(s_b2),
        .ex_fwd_sel_rs1(s_f1), .ex_fwd_sel_rs2(s_f2),
        .stall_if(s_st_if), .stall_id(s_st_id), .flush_if_id(s_fl_ifid), .flush_id_ex(s_fl_idex),
        .stall_count(s_sc), .flush_count(s_fc)
    );

    typedef struct packed {
        logic        b1, b2;
        logic [1:0]  f1, f2;
        logic        st, fl;
        logic [31:0] sc, fc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int unsigned exp_stall = 0;
    int unsigned exp_flush = 0;

    // Drive one ID-stage vector just after the edge and queue its expected response.
    task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mp,
                         input logic eb1, input logic eb2, input logic [1:0] ef1,
                         input logic [1:0] ef2, input logic est, input logic efl);
        exp_t e;
        @(posedge clk);
        #1;
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; ex_mispredict = mp;
        e.b1 = eb1; e.b2 = eb2; e.f1 = ef1; e.f2 = ef2; e.st = est; e.fl = efl;
        e.sc = 32'(exp_stall); e.fc = 32'(exp_flush);
        q.push_back(e);
        if (est) exp_stall++;
        if (efl) exp_flush++;
    endtask

    task automatic nop(input logic [1:0] ef1, input logic [1:0] ef2);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ef1, ef2, 0, 0);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) nop(2'b00, 2'b00);
    endtask

    exp_t       m_e;
    logic [2:0] m_ssc, m_sfc;

    always @(negedge clk) begin
        if (q.size() != 0) begin
            m_e   = q.pop_front();
            m_ssc = (m_e.sc > 32'd7) ? 3'd7 : m_e.sc[2:0];
            m_sfc = (m_e.fc > 32'd7) ? 3'd7 : m_e.fc[2:0];
            total++;
            if (b1 !== m_e.b1 || b2 !== m_e.b2 || f1 !== m_e.f1 || f2 !== m_e.f2 ||
                st_if !== m_e.st || st_id !== m_e.st || fl_ifid !== m_e.fl || fl_idex !== m_e.fl ||
                sc !== m_e.sc || fc !== m_e.fc ||
                s_b1 !== m_e.b1 || s_b2 !== m_e.b2 || s_f1 !== m_e.f1 || s_f2 !== m_e.f2 ||
                s_st_if !== m_e.st || s_st_id !== m_e.st || s_fl_ifid !== m_e.fl ||
                s_fl_idex !== m_e.fl || s_sc !== m_ssc || s_fc !== m_sfc) begin
                bad++;
                $display("FAIL vec%0d @%0t: got byp=%b%b fwd=%b/%b stall=%b%b flush=%b%b sc=%0d fc=%0d sat{ctl=%b%b%b%b%b%b%b%b sc=%0d fc=%0d} want byp=%b%b fwd=%b/%b stall=%b flush=%b sc=%0d fc=%0d sat_sc=%0d sat_fc=%0d",
                         total, $time, b1, b2, f1, f2, st_if, st_id, fl_ifid, fl_idex, sc, fc,
                         s_b1, s_b2, s_f1, s_f2, s_st_if, s_st_id, s_fl_ifid, s_fl_idex, s_sc, s_fc,
                         m_e.b1, m_e.b2, m_e.f1, m_e.f2, m_e.st, m_e.fl, m_e.sc, m_e.fc, m_ssc, m_sfc);
            end
        end
    end

    initial begin
        // Reset held with a live load in ID: everything must read zero.
        id_valid = 1; id_rs1 = 5; id_rs2 = 7; id_use_rs1 = 1; id_use_rs2 = 1;
        id_rd = 5; id_reg_write = 1; id_mem_read = 1; ex_mispredict = 0;
        issue(1, 5, 7, 1, 1, 5, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        issue(1, 7, 5, 1, 1, 7, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        @(posedge clk);
        #1;
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_reg_write = 0; id_mem_read = 0;
        rst = 0;
        nops(3);

        // ALU RAW, back-to-back: MEM forward on rs1.
        issue(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        issue(1, 5, 6, 1, 1, 8, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        nop(2'b01, 2'b00);
        nops(3);

        // One NOP between: WB forward.
        issue(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        nop(2'b00, 2'b00);
        issue(1, 5, 6, 1, 1, 8, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        nop(2'b10, 2'b00);
        nops(3);

        // Two NOPs between: ID bypass on both operands.
        issue(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        nops(2);
        issue(1, 5, 5, 1, 1, 8, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0);
        nops(3);

        // Load-use on rs2: one stall, bubble, then WB forward.
        issue(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        issue(1, 3, 7, 1, 1, 9, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        issue(1, 3, 7, 1, 1, 9, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        nop(2'b00, 2'b10);
        nops(3);

        // Load to x0 followed by x0 readers: nothing happens.
        issue(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        issue(1, 0, 0, 1, 1, 10, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        nops(4);

        // Matching rs1 that the consumer does not read: no forward.
        issue(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        issue(1, 3, 4, 0, 1, 11, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        nops(4);

        // Mispredict coinciding with load-use: flush wins, EX bubbled.
        issue(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        issue(1, 3, 7, 1, 1, 9, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 1);
        issue(1, 3, 7, 1, 1, 12, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        nop(2'b00, 2'b10);
        nops(3);

        // Chain of dependent loads: ten stalls, pushes the 3-bit counter past 7.
        issue(1, 7, 0, 1, 0, 7, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        issue(1, 7, 0, 1, 0, 7, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        issue(1, 7, 0, 1, 0, 7, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        for (int k = 0; k < 9; k++) begin
            issue(1, 7, 0, 1, 0, 7, 1, 1, 0, 1, 0, 2'b10, 2'b00, 1, 0);
            issue(1, 7, 0, 1, 0, 7, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        end
        nop(2'b10, 2'b00);
        nops(3);

        // Reset in the middle of a stall cycle: stall drops without a clock edge.
        issue(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        @(posedge clk);
        #1;
        id_valid = 1; id_rs1 = 3; id_rs2 = 7; id_use_rs1 = 1; id_use_rs2 = 1;
        id_rd = 9; id_reg_write = 1; id_mem_read = 0; ex_mispredict = 0;
        #1;
        rst = 1;
        exp_stall = 0;
        exp_flush = 0;
        q.push_back('0);
        @(posedge clk);
        #1;
        rst = 0;
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_reg_write = 0;
        nops(3);

        for (int w = 0; w < 10 && q.size() != 0; w++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected entries never checked, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Central hazard and forwarding controller for the 5-stage RV32I pipeline.
- Drives the ID-stage write-back bypass selects (mux_Sel_RAW_ID_rs1/rs2) and the EX-stage forwarding selects.
- Generates the load-use stall and the mispredict flush.
- Keeps its own shadow pipeline of destination-register info (EX/MEM/WB slots), advanced in lockstep with the datapath pipeline registers.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, width of the saturating stall and flush event counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  REG_AW  ID source register 1
- id_rs2  in  REG_AW  ID source register 2
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_rd  in  REG_AW  ID destination register
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- ex_mispredict  in  1  EX-resolved branch/jump mispredict (YAGS correction)
- mux_Sel_RAW_ID_rs1  out  1  1 = ID rs1 takes WB data
- mux_Sel_RAW_ID_rs2  out  1  1 = ID rs2 takes WB data
- ex_fwd_sel_rs1  out  2  00 ID/EX operand, 01 MEM ALU result, 10 WB data
- ex_fwd_sel_rs2  out  2  same encoding as ex_fwd_sel_rs1
- stall_if  out  1  hold PC and IF/ID
- stall_id  out  1  hold ID; insert bubble into ID/EX
- flush_if_id  out  1  squash IF/ID
- flush_id_ex  out  1  squash ID/EX
- stall_count  out  CNT_W  saturating count of load-use stall cycles
- flush_count  out  CNT_W  saturating count of mispredict flushes

Behaviour:
- Slot contents (registered): EX, MEM, WB each hold {valid, rd, reg_write, mem_read, rs1, rs2, use_rs1, use_rs2}.
- Reset (async, rst=1): all slot valid bits = 0 and counters = 0. Therefore every output is 0 (selects 0, stalls 0, flushes 0).
- A slot "writes" only when valid & reg_write & rd != 0. x0 never forwards and never stalls.
- ID bypass (combinational from WB slot and ID inputs): mux_Sel_RAW_ID_rsN = 1 iff WB slot writes and WB.rd == id_rsN and id_use_rsN.
- EX forwarding (combinational from registered slots), rsN of EX slot:
  - MEM slot writes, is not a load, and rd matches -> 01.
  - Else WB slot writes and rd matches -> 10.
  - Else 00.
  - MEM has priority over WB, since it is the younger producer.
- Load-use hazard: load_use = id_valid & EX.valid & EX.mem_read & EX writes & ((id_use_rs1 & EX.rd==id_rs1) | (id_use_rs2 & EX.rd==id_rs2)).
  - Asserts stall_if = stall_id = 1 for exactly one cycle.
  - The load then sits in MEM; next cycle load_use deasserts (EX holds the bubble).
  - The dependent instruction then reaches EX while the load is in WB, so the select is 10.
- Mispredict: ex_mispredict=1 -> flush_if_id = flush_id_ex = 1 in that cycle, and stalls are forced to 0. Mispredict beats load-use when both are true.
- Slot advance on every rising clk:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= bubble (valid=0) if load_use or ex_mispredict, else the ID fields with valid = id_valid.
- Counters:
  - stall_count += 1 on each cycle with load_use & !ex_mispredict.
  - flush_count += 1 on each ex_mispredict cycle.
  - Both saturate at all-ones with no wrap.
- Reset asserted mid-stall clears slots immediately, and the stall output drops asynchronously.

Decomposition:
- Shared package hazard_pkg holds:
  - fwd_sel_e enum: FWD_NONE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - slot_t packed struct for the slot fields.
  - REG_ZERO constant.
- One natural sub-module: sat_counter (parameterised width, increment enable, async reset), instanced twice.

Test Plan:
- Reset: rst=1 with arbitrary ID inputs -> all outputs 0; after release with id_valid=0 for 3 cycles, outputs stay 0.
- ALU RAW chain: add x5 (rd=5, rw) then sub using rs1=5 next cycle -> ex_fwd_sel_rs1=01 when sub is in EX. With one intervening NOP -> 10. With two NOPs -> mux_Sel_RAW_ID_rs1=1 in ID.
- Load-use: lw x7 then add rs2=7 -> stall_if=stall_id=1 for exactly 1 cycle, EX gets a bubble, then ex_fwd_sel_rs2=10, stall_count=1.
- x0 and unused operands: lw x0 followed by a user of rs1=0 -> no stall, selects 00. Producer rd=3 with consumer id_use_rs1=0, id_rs1=3 -> no forward, no stall.
- Mispredict with simultaneous load-use -> flush_if_id=flush_id_ex=1, stall=0, flush_count=1, stall_count unchanged, EX slot invalid next cycle.
- Saturation: force 2^CNT_W-1 via a reduced CNT_W=3 build; 8 stalls -> stall_count holds at 7.
